uart_byte_fifo: RTL
===================

// Module: uart_byte_fifo
// PURPOSE
//  Single-clock byte buffer between uart_rx (producer) and uart_tx (consumer).
//  - Captures each received byte on its one-cycle valid strobe and stores it in a circular FIFO.
//  - Replays bytes to uart_tx one at a time, waiting for the transmitter's busy flag to clear.
//  - Back-to-back received bytes are not lost while a transmit is in progress.
// PARAMETERS
//  DATA_WIDTH   8   byte width; matches `UART_DATA_WIDTH
//  ADDR_WIDTH   4   log2 FIFO depth (depth = 16)
//  BUSY_WAIT    4   cycles to wait for busy_i to rise after a strobe before assuming done
// PORTS
//  clk_i      in   1           system clock; all logic on rising edge
//  rst_i      in   1           asynchronous, active-low reset
//  rx_data_i  in   DATA_WIDTH  byte from uart_rx
//  rx_v_i     in   1           one-cycle strobe: rx_data_i valid
//  tx_data_o  out  DATA_WIDTH  byte to uart_tx; stable from strobe until next strobe
//  tx_v_o     out  1           one-cycle strobe: start transmit of tx_data_o
//  busy_i     in   1           uart_tx busy flag
//  empty_o    out  1           FIFO holds no bytes
//  full_o     out  1           FIFO holds 2**ADDR_WIDTH bytes
//  overflow_o out  1           sticky: a byte was dropped
// BEHAVIOUR
//  Reset (rst_i=0, async)
//   - wr_ptr=rd_ptr=0, count=0; tx_data_o=0, tx_v_o=0; empty_o=1, full_o=0, overflow_o=0.
//   - FSM=IDLE. Mid-transmit reset discards all stored bytes; no strobe is issued.
//  Storage
//   - count is ADDR_WIDTH+1 bits. Pointers are ADDR_WIDTH bits and wrap modulo depth.
//   - empty_o = (count==0); full_o = (count==depth). Both registered.
//  Push
//   - A push is rx_v_i=1 and (!full_o or pop in the same cycle).
//   - On push: mem[wr_ptr] <= rx_data_i; wr_ptr++.
//   - rx_v_i=1 while full with no pop: byte dropped, overflow_o <= 1 (held until reset).
//  Pop
//   - Pop occurs only in ISSUE: tx_data_o <= mem[rd_ptr]; rd_ptr++.
//   - tx_v_o is registered, high exactly the cycle after ISSUE.
//   - Push and pop in the same cycle: count unchanged.
//   - Push into an empty FIFO: byte is poppable on the following cycle (no read-during-write bypass).
//  Drain FSM
//   - IDLE     : !empty_o && !busy_i -> ISSUE
//   - ISSUE    : pop; -> WAIT_HI; wait counter cleared
//   - WAIT_HI  : busy_i=1 -> WAIT_LO; else counter++; counter==BUSY_WAIT -> IDLE
//   - WAIT_LO  : busy_i=0 -> IDLE
//   - Minimum spacing between tx_v_o strobes = 3 cycles plus the busy period.
//   - busy_i is never ignored: no strobe is issued while busy_i=1.
//  Latency: rx_v_i into an empty idle FIFO -> tx_v_o 3 cycles later (push, IDLE, ISSUE).
// CONFIGURATION
//  UART_FIFO_STATS_EN
//   - Defined: adds output level_o [ADDR_WIDTH:0] (= count) and output drop_cnt_o [7:0].
//     drop_cnt_o increments per dropped byte, saturates at 255, resets to 0.
//   - Undefined: neither port nor counter exists; overflow_o unaffected.
// TESTING
//  1. Reset, single rx_v_i with 0xA5 -> tx_v_o pulses 3 cycles later, tx_data_o=0xA5; empty_o returns 1.
//  2. Push 0x01..0x05 back-to-back; model busy_i high 10 cycles per strobe
//     -> five strobes in order 0x01..0x05; no strobe while busy_i=1.
//  3. Hold busy_i=1, push 17 bytes -> full_o=1 after 16th; 17th dropped; overflow_o=1;
//     with STATS_EN drop_cnt_o=1, level_o=16.
//  4. Full FIFO, push coinciding with ISSUE pop -> byte accepted, count stays 16, overflow_o stays 0.
//  5. busy_i tied 0, push 0x3C -> strobe, then IDLE after BUSY_WAIT=4 cycles; next byte still issued.
//  6. Assert rst_i=0 in WAIT_LO with 3 bytes queued -> all outputs at reset values immediately;
//     no further tx_v_o after release.
//  7. Push 40 bytes, drain between pushes so pointers wrap twice -> output sequence matches input exactly.

Source files
------------

// File: rtl/uart_byte_fifo_if.sv
// Handshake bundle between uart_byte_fifo and its rx/tx neighbours.
// The level_o and drop_cnt_o members exist only when UART_FIFO_STATS_EN is defined.
interface uart_byte_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] rx_data_i;
   logic                  rx_v_i;
   logic [DATA_WIDTH-1:0] tx_data_o;
   logic                  tx_v_o;
   logic                  busy_i;
   logic                  empty_o;
   logic                  full_o;
   logic                  overflow_o;
`ifdef UART_FIFO_STATS_EN
   logic [ADDR_WIDTH:0]   level_o;
   logic [7:0]            drop_cnt_o;

   modport slave (
      input  rx_data_i, rx_v_i, busy_i,
      output tx_data_o, tx_v_o, empty_o, full_o, overflow_o, level_o, drop_cnt_o
   );
   modport master (
      output rx_data_i, rx_v_i, busy_i,
      input  tx_data_o, tx_v_o, empty_o, full_o, overflow_o, level_o, drop_cnt_o
   );
`else
   modport slave (
      input  rx_data_i, rx_v_i, busy_i,
      output tx_data_o, tx_v_o, empty_o, full_o, overflow_o
   );
   modport master (
      output rx_data_i, rx_v_i, busy_i,
      input  tx_data_o, tx_v_o, empty_o, full_o, overflow_o
   );
`endif
endinterface

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO from uart_rx to uart_tx with a busy-aware drain FSM.
// Define UART_FIFO_STATS_EN to add level_o and a saturating drop_cnt_o.
module uart_byte_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int BUSY_WAIT  = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   uart_byte_fifo_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int WCW   = $clog2(BUSY_WAIT + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_WAIT_HI = 2'd2;
   localparam logic [1:0] S_WAIT_LO = 2'd3;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic                  overflow_q, overflow_d;
   logic                  tx_v_q, tx_v_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic [1:0]            state_q, state_d;
   logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
   logic                  push, pop, drop;

   // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
   always_comb begin
      pop  = (state_q == S_ISSUE);
      push = bus.rx_v_i && (!full_q || pop);
      drop = bus.rx_v_i && full_q && !pop;

      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      tx_data_d  = tx_data_q;
      tx_v_d     = 1'b0;
      overflow_d = overflow_q || drop;
      count_d    = count_q;

      case (state_q)
         S_IDLE: begin
            if (!empty_q && !bus.busy_i) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            tx_data_d  = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + 1'b1;
            tx_v_d     = 1'b1;
            wait_cnt_d = '0;
            state_d    = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (bus.busy_i) begin
               state_d = S_WAIT_LO;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
               if (wait_cnt_d == WCW'(BUSY_WAIT)) state_d = S_IDLE;
            end
         end
         S_WAIT_LO: begin
            if (!bus.busy_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      empty_d = (count_d == '0);
      full_d  = (count_d == (ADDR_WIDTH + 1)'(DEPTH));
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         tx_data_q  <= '0;
         tx_v_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
         tx_data_q  <= tx_data_d;
         tx_v_q     <= tx_v_d;
      end
   end

   // Storage needs no reset: only slots behind wr_ptr are ever read.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= bus.rx_data_i;
   end

   assign bus.tx_data_o  = tx_data_q;
   assign bus.tx_v_o     = tx_v_q;
   assign bus.empty_o    = empty_q;
   assign bus.full_o     = full_q;
   assign bus.overflow_o = overflow_q;

`ifdef UART_FIFO_STATS_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) drop_cnt_q <= '0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign bus.level_o    = count_q;
   assign bus.drop_cnt_o = drop_cnt_q;
`endif
endmodule
